// File: rtl/menu_sel_ctl_if.sv
// Video, pointer and selection signals of the menu selection controller.
interface menu_sel_ctl_if #(
  parameter int unsigned IDX_W = 2
);
  logic [10:0]      hcount_in;
  logic [10:0]      vcount_in;
  logic             hsync_in;
  logic             vsync_in;
  logic             hblnk_in;
  logic             vblnk_in;
  logic [11:0]      rgb_in;
  logic [11:0]      xpos;
  logic [11:0]      ypos;
  logic             mouse_left;
  logic             hsync_out;
  logic             vsync_out;
  logic [11:0]      rgb_out;
  logic [IDX_W-1:0] hover_idx;
  logic             hover_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_stb;

  // Upstream video source / pointer side
  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    output xpos, ypos, mouse_left,
    input  hsync_out, vsync_out, rgb_out, hover_idx, hover_valid, sel_idx, sel_stb
  );

  // Controller side
  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in,
    input  xpos, ypos, mouse_left,
    output hsync_out, vsync_out, rgb_out, hover_idx, hover_valid, sel_idx, sel_stb
  );
endinterface

// File: rtl/menu_sel_ctl.sv
// Menu selection controller: per-frame pointer hit test, press/release
// confirm FSM and hover/press/selected border overlay on the video stream.
module menu_sel_ctl #(
  parameter int unsigned N_ITEMS     = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned ITEM_X      = 384,
  parameter int unsigned ITEM_Y0     = 72,
  parameter int unsigned ITEM_PITCH  = 200,
  parameter int unsigned ITEM_W      = 256,
  parameter int unsigned ITEM_H      = 64,
  parameter int unsigned BORDER      = 4,
  parameter logic [11:0] HOVER_COLOR = 12'hFF0,
  parameter logic [11:0] PRESS_COLOR = 12'hF80,
  parameter logic [11:0] SEL_COLOR   = 12'h0F0,
  parameter int unsigned DEFAULT_SEL = 0
) (
  input  logic          clk,
  input  logic          rst,
  menu_sel_ctl_if.slave bus
);

  localparam logic [IDX_W-1:0] DEFAULT_SEL_W = IDX_W'(DEFAULT_SEL);
  localparam logic [11:0]      X_LO          = 12'(ITEM_X);
  localparam logic [11:0]      X_HI          = 12'(ITEM_X + ITEM_W);
  localparam logic [11:0]      X_LO_IN       = 12'(ITEM_X + BORDER);
  localparam logic [11:0]      X_HI_IN       = 12'(ITEM_X + ITEM_W - BORDER);

  // Index width must be able to address every item
  if (N_ITEMS < 1 || (64'd1 << IDX_W) < 64'(N_ITEMS)) begin : g_bad_cfg
    $error("menu_sel_ctl: IDX_W too narrow for N_ITEMS");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_WAIT_REL,
    S_CONFIRM
  } state_t;

  function automatic logic [11:0] item_top(input int unsigned k);
    return 12'(ITEM_Y0 + k * ITEM_PITCH);
  endfunction

  function automatic logic [11:0] item_bot(input int unsigned k);
    return 12'(ITEM_Y0 + k * ITEM_PITCH + ITEM_H);
  endfunction

  function automatic logic in_rect(input int unsigned k, input logic [11:0] x,
                                   input logic [11:0] y);
    return (x >= X_LO) && (x < X_HI) && (y >= item_top(k)) && (y < item_bot(k));
  endfunction

  function automatic logic in_border(input int unsigned k, input logic [11:0] x,
                                     input logic [11:0] y);
    logic near_edge;
    near_edge = (x < X_LO_IN) || (x >= X_HI_IN) ||
                (y < 12'(item_top(k) + 12'(BORDER))) ||
                (y >= 12'(item_bot(k) - 12'(BORDER)));
    return in_rect(k, x, y) && near_edge;
  endfunction

  // Per-frame pointer samples
  logic             vsync_prev;
  logic             vs_rise_c;
  logic [11:0]      x_smp;
  logic [11:0]      y_smp;
  logic             btn_smp;
  logic             btn_prev;
  logic             smp_vld;

  // Hit test and selection state
  logic             hit_c;
  logic [IDX_W-1:0] hit_idx_c;
  logic             press_c;
  logic             release_c;
  logic             press_load_c;
  logic             confirm_c;
  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] press_idx;
  logic [IDX_W-1:0] hover_idx;
  logic             hover_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_stb;

  // Video pipeline
  logic [11:0]        h12_c;
  logic [11:0]        v12_c;
  logic               hs1;
  logic               vs1;
  logic               blank1;
  logic [11:0]        rgb1;
  logic [N_ITEMS-1:0] border1;
  logic               sel_bdr_c;
  logic               press_bdr_c;
  logic               hover_bdr_c;
  logic [11:0]        rgb_nxt_c;
  logic               hsync_out;
  logic               vsync_out;
  logic [11:0]        rgb_out;

  assign vs_rise_c = bus.vsync_in & ~vsync_prev;
  assign press_c   = smp_vld & btn_smp & ~btn_prev;
  assign release_c = smp_vld & ~btn_smp & btn_prev;
  assign h12_c     = {1'b0, bus.hcount_in};
  assign v12_c     = {1'b0, bus.vcount_in};

  // Capture pointer and button once per frame on the vsync rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev <= 1'b0;
      x_smp      <= '0;
      y_smp      <= '0;
      btn_smp    <= 1'b0;
      btn_prev   <= 1'b0;
      smp_vld    <= 1'b0;
    end else begin
      vsync_prev <= bus.vsync_in;
      smp_vld    <= vs_rise_c;
      if (vs_rise_c) begin
        x_smp    <= bus.xpos;
        y_smp    <= bus.ypos;
        btn_prev <= btn_smp;
        btn_smp  <= bus.mouse_left;
      end
    end
  end

  // Which item the sampled pointer is over; lowest index wins
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int unsigned k = 0; k < N_ITEMS; k++) begin
      if (!hit_c && in_rect(k, x_smp, y_smp)) begin
        hit_c     = 1'b1;
        hit_idx_c = IDX_W'(k);
      end
    end
  end

  // Hover follows the samples; index holds when nothing is hit
  always_ff @(posedge clk) begin
    if (rst) begin
      hover_valid <= 1'b0;
      hover_idx   <= '0;
    end else if (hit_c) begin
      hover_valid <= 1'b1;
      hover_idx   <= hit_idx_c;
    end else begin
      hover_valid <= 1'b0;
    end
  end

  // Selection FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Selection FSM next state, advanced only by frame-sample button edges
  always_comb begin
    state_nxt    = state;
    press_load_c = 1'b0;
    confirm_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (press_c) begin
          if (hit_c) begin
            press_load_c = 1'b1;
            state_nxt    = S_PRESS;
          end else begin
            state_nxt = S_WAIT_REL;
          end
        end
      end
      S_PRESS: begin
        if (release_c) begin
          state_nxt = (hit_c && (hit_idx_c == press_idx)) ? S_CONFIRM : S_IDLE;
        end
      end
      S_WAIT_REL: begin
        if (release_c) state_nxt = S_IDLE;
      end
      S_CONFIRM: begin
        confirm_c = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pressed item latch, confirmed selection and its strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      press_idx <= '0;
      sel_idx   <= DEFAULT_SEL_W;
      sel_stb   <= 1'b0;
    end else begin
      sel_stb <= confirm_c;
      if (press_load_c) press_idx <= hit_idx_c;
      if (confirm_c)    sel_idx   <= press_idx;
    end
  end

  // Stage 1: delay timing/colour and flag pixels lying on an item border
  always_ff @(posedge clk) begin
    if (rst) begin
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      blank1  <= 1'b0;
      rgb1    <= '0;
      border1 <= '0;
    end else begin
      hs1    <= bus.hsync_in;
      vs1    <= bus.vsync_in;
      blank1 <= bus.hblnk_in | bus.vblnk_in;
      rgb1   <= bus.rgb_in;
      for (int unsigned k = 0; k < N_ITEMS; k++) begin
        border1[k] <= in_border(k, h12_c, v12_c);
      end
    end
  end

  // Stage 2 colour pick: blanking, selected, pressed, hovered, passthrough
  always_comb begin
    sel_bdr_c   = 1'b0;
    press_bdr_c = 1'b0;
    hover_bdr_c = 1'b0;
    for (int unsigned k = 0; k < N_ITEMS; k++) begin
      if (border1[k]) begin
        if (IDX_W'(k) == sel_idx)   sel_bdr_c   = 1'b1;
        if (IDX_W'(k) == press_idx) press_bdr_c = 1'b1;
        if (IDX_W'(k) == hover_idx) hover_bdr_c = 1'b1;
      end
    end
    if (blank1)                             rgb_nxt_c = 12'h000;
    else if (sel_bdr_c)                     rgb_nxt_c = SEL_COLOR;
    else if (press_bdr_c && state == S_PRESS) rgb_nxt_c = PRESS_COLOR;
    else if (hover_bdr_c && hover_valid)    rgb_nxt_c = HOVER_COLOR;
    else                                    rgb_nxt_c = rgb1;
  end

  // Stage 2 output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      rgb_out   <= '0;
    end else begin
      hsync_out <= hs1;
      vsync_out <= vs1;
      rgb_out   <= rgb_nxt_c;
    end
  end

  assign bus.hsync_out   = hsync_out;
  assign bus.vsync_out   = vsync_out;
  assign bus.rgb_out     = rgb_out;
  assign bus.hover_idx   = hover_idx;
  assign bus.hover_valid = hover_valid;
  assign bus.sel_idx     = sel_idx;
  assign bus.sel_stb     = sel_stb;

endmodule

// File: tb/tb_menu_sel_ctl.sv
// Scoreboard bench for menu_sel_ctl: frame-level pointer model plus
// per-pixel expected colours, checked by independent monitors.
module tb_menu_sel_ctl;

  localparam int N_ITEMS     = 4;
  localparam int IDX_W       = 2;
  localparam int ITEM_X      = 384;
  localparam int ITEM_Y0     = 72;
  localparam int ITEM_PITCH  = 200;
  localparam int ITEM_W      = 256;
  localparam int ITEM_H      = 64;
  localparam int BORDER      = 4;
  localparam logic [11:0] HOVER_COLOR = 12'hFF0;
  localparam logic [11:0] PRESS_COLOR = 12'hF80;
  localparam logic [11:0] SEL_COLOR   = 12'h0F0;
  localparam int DEFAULT_SEL = 0;

  typedef struct {
    longint           due;
    int               h;
    int               v;
    logic [11:0]      rgb;
    logic             hs;
    logic             vs;
    logic             hv;
    logic [IDX_W-1:0] hi;
    logic [IDX_W-1:0] si;
  } px_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  menu_sel_ctl_if #(.IDX_W(IDX_W)) bus ();

  menu_sel_ctl #(
    .N_ITEMS(N_ITEMS), .IDX_W(IDX_W), .ITEM_X(ITEM_X), .ITEM_Y0(ITEM_Y0),
    .ITEM_PITCH(ITEM_PITCH), .ITEM_W(ITEM_W), .ITEM_H(ITEM_H), .BORDER(BORDER),
    .HOVER_COLOR(HOVER_COLOR), .PRESS_COLOR(PRESS_COLOR), .SEL_COLOR(SEL_COLOR),
    .DEFAULT_SEL(DEFAULT_SEL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;
  px_t    px_q[$];
  int     sel_q[$];
  px_t    mon_e;
  int     mon_sel;
  logic   stb_prev = 1'b0;

  // Reference model state, one update per frame
  int m_sel       = DEFAULT_SEL;
  int m_press     = 0;
  bit m_pressing  = 0;
  bit m_waiting   = 0;
  bit m_prev_btn  = 0;
  bit m_hov_valid = 0;
  int m_hov_idx   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int hit_item(input int x, input int y);
    int k;
    if (x < ITEM_X || x >= ITEM_X + ITEM_W || y < ITEM_Y0) return -1;
    k = (y - ITEM_Y0) / ITEM_PITCH;
    if (k >= N_ITEMS || (y - ITEM_Y0) % ITEM_PITCH >= ITEM_H) return -1;
    return k;
  endfunction

  // On the border when the nearest rectangle edge is closer than BORDER
  function automatic bit on_border(input int k, input int x, input int y);
    int top, d;
    if (hit_item(x, y) != k) return 0;
    top = ITEM_Y0 + k * ITEM_PITCH;
    d = x - ITEM_X;
    if (ITEM_X + ITEM_W - 1 - x < d) d = ITEM_X + ITEM_W - 1 - x;
    if (y - top < d) d = y - top;
    if (top + ITEM_H - 1 - y < d) d = top + ITEM_H - 1 - y;
    return d < BORDER;
  endfunction

  function automatic logic [11:0] exp_rgb(input int h, input int v, input bit blank,
                                          input logic [11:0] rgb);
    if (blank) return 12'h000;
    if (on_border(m_sel, h, v)) return SEL_COLOR;
    if (m_pressing && on_border(m_press, h, v)) return PRESS_COLOR;
    if (m_hov_valid && on_border(m_hov_idx, h, v)) return HOVER_COLOR;
    return rgb;
  endfunction

  // Drive one pixel and queue its expected output two cycles later
  task automatic pixel(input int h, input int v, input bit blank, input logic [11:0] rgb);
    px_t e;
    bit  r;
    @(negedge clk);
    r = 1'($urandom_range(0, 1));
    bus.hcount_in = 11'(h);
    bus.vcount_in = 11'(v);
    bus.hblnk_in  = blank & r;
    bus.vblnk_in  = blank & ~r;
    bus.hsync_in  = 1'($urandom_range(0, 1));
    bus.vsync_in  = 1'($urandom_range(0, 1));
    bus.rgb_in    = rgb;
    e.due = cyc + 2;
    e.h   = h;
    e.v   = v;
    e.rgb = exp_rgb(h, v, blank, rgb);
    e.hs  = bus.hsync_in;
    e.vs  = bus.vsync_in;
    e.hv  = m_hov_valid;
    e.hi  = IDX_W'(m_hov_idx);
    e.si  = IDX_W'(m_sel);
    px_q.push_back(e);
  endtask

  // Present a new pointer state at a vsync rising edge and advance the model
  task automatic frame(input int x, input int y, input bit btn);
    int k;
    bit pr, rl;
    repeat (3) @(negedge clk);
    k  = hit_item(x, y);
    pr = btn && !m_prev_btn;
    rl = !btn && m_prev_btn;
    m_prev_btn = btn;
    if (m_pressing) begin
      if (rl) begin
        m_pressing = 0;
        if (k == m_press) begin
          m_sel = k;
          sel_q.push_back(k);
        end
      end
    end else if (m_waiting) begin
      if (rl) m_waiting = 0;
    end else if (pr) begin
      if (k >= 0) begin
        m_pressing = 1;
        m_press    = k;
      end else begin
        m_waiting = 1;
      end
    end
    if (k >= 0) begin
      m_hov_valid = 1;
      m_hov_idx   = k;
    end else begin
      m_hov_valid = 0;
    end
    @(negedge clk);
    bus.vsync_in   = 1'b0;
    bus.xpos       = 12'(x);
    bus.ypos       = 12'(y);
    bus.mouse_left = btn;
    @(negedge clk);
    bus.vsync_in = 1'b1;
    @(negedge clk);
    bus.vsync_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    repeat (3) @(negedge clk);
    bus.hcount_in  = '0;
    bus.vcount_in  = '0;
    bus.hsync_in   = 1'b0;
    bus.vsync_in   = 1'b0;
    bus.hblnk_in   = 1'b0;
    bus.vblnk_in   = 1'b0;
    bus.rgb_in     = '0;
    bus.xpos       = '0;
    bus.ypos       = '0;
    bus.mouse_left = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_sel = DEFAULT_SEL; m_press = 0; m_pressing = 0; m_waiting = 0;
    m_prev_btn = 0; m_hov_valid = 0; m_hov_idx = 0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rgb_out"}, 32'(bus.rgb_out), 32'h0);
    chk({tag, "_sel_idx"}, 32'(bus.sel_idx), 32'(DEFAULT_SEL));
    chk({tag, "_sel_stb"}, 32'(bus.sel_stb), 32'h0);
    chk({tag, "_hover_valid"}, 32'(bus.hover_valid), 32'h0);
    chk({tag, "_hsync_out"}, 32'(bus.hsync_out), 32'h0);
    chk({tag, "_vsync_out"}, 32'(bus.vsync_out), 32'h0);
  endtask

  // Pixel monitor: every cycle the pipeline presents one composited pixel
  always @(negedge clk) begin
    while (px_q.size() > 0 && px_q[0].due <= cyc) begin
      mon_e = px_q.pop_front();
      chk($sformatf("pix_due(%0d,%0d)", mon_e.h, mon_e.v), 32'(mon_e.due), 32'(cyc));
      chk($sformatf("rgb(%0d,%0d)", mon_e.h, mon_e.v), 32'(bus.rgb_out), 32'(mon_e.rgb));
      chk("hsync_lat", 32'(bus.hsync_out), 32'(mon_e.hs));
      chk("vsync_lat", 32'(bus.vsync_out), 32'(mon_e.vs));
      chk("hover_valid", 32'(bus.hover_valid), 32'(mon_e.hv));
      if (mon_e.hv) chk("hover_idx", 32'(bus.hover_idx), 32'(mon_e.hi));
      chk("sel_idx", 32'(bus.sel_idx), 32'(mon_e.si));
    end
  end

  // Selection monitor: each strobe must match a queued confirm
  always @(negedge clk) begin
    if (!rst && bus.sel_stb) begin
      chk("sel_stb_width", 32'(stb_prev), 32'h0);
      if (sel_q.size() == 0) begin
        chk("sel_stb_unexpected", 32'h1, 32'h0);
      end else begin
        mon_sel = sel_q.pop_front();
        chk("sel_stb_idx", 32'(bus.sel_idx), 32'(mon_sel));
      end
    end
    stb_prev = bus.sel_stb;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, top;
    bit btn;
    do_reset();
    reset_checks("reset");
    repeat (6) @(negedge clk);
    reset_checks("idle_hold");

    // Passthrough and 2-cycle latency with pointer off all items
    frame(100, 100, 0);
    pixel(100, 100, 0, 12'h123);
    pixel(101, 100, 0, 12'h456);

    // Hover over item 1
    frame(400, 300, 0);
    pixel(384, 272, 0, 12'h123);
    pixel(500, 300, 0, 12'h321);
    pixel(387, 300, 0, 12'h111);
    pixel(388, 300, 0, 12'h222);
    pixel(639, 335, 0, 12'h333);
    pixel(640, 300, 0, 12'h444);

    // Confirm item 2
    frame(400, 500, 1);
    pixel(384, 472, 0, 12'h555);
    frame(400, 510, 0);
    pixel(384, 472, 0, 12'h666);
    pixel(500, 535, 0, 12'h777);

    // Abort: release off the pressed item, and press over nothing
    frame(400, 700, 1);
    pixel(400, 672, 0, 12'h888);
    frame(100, 100, 0);
    frame(100, 100, 1);
    frame(400, 100, 0);
    pixel(400, 72, 0, 12'h999);

    // Hover over selected item, blanking inside a border
    frame(400, 500, 0);
    pixel(384, 472, 0, 12'hABC);
    pixel(384, 472, 1, 12'hABC);
    pixel(420, 474, 1, 12'hDEF);

    // Pressed item keeps PRESS while pointer leaves; reset drops it
    frame(400, 100, 1);
    pixel(384, 72, 0, 12'h0AA);
    frame(100, 100, 1);
    pixel(384, 72, 0, 12'h0BB);
    pixel(384, 472, 0, 12'h0CC);
    do_reset();
    reset_checks("rst_press");
    frame(400, 100, 0);
    pixel(384, 72, 0, 12'h0DD);

    // Randomized frames, biased toward item areas
    btn = 0;
    for (int f = 0; f < 45; f++) begin
      if ($urandom_range(0, 2) == 0) btn = ~btn;
      if ($urandom_range(0, 3) == 0) frame($urandom_range(0, 1023), $urandom_range(0, 900), btn);
      else begin
        k = $urandom_range(0, N_ITEMS - 1);
        frame(ITEM_X + $urandom_range(0, ITEM_W - 1),
              ITEM_Y0 + k * ITEM_PITCH + $urandom_range(0, ITEM_H - 1), btn);
      end
      for (int p = 0; p < 10; p++) begin
        k   = $urandom_range(0, N_ITEMS - 1);
        top = ITEM_Y0 + k * ITEM_PITCH;
        pixel(ITEM_X - 6 + $urandom_range(0, ITEM_W + 11),
              top - 6 + $urandom_range(0, ITEM_H + 11),
              ($urandom_range(0, 7) == 0), 12'($urandom));
      end
    end

    repeat (6) @(negedge clk);
    chk("px_queue_drained", 32'(px_q.size()), 32'h0);
    chk("sel_queue_drained", 32'(sel_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/menu_sel_ctl.md
Name: menu_sel_ctl

Overview:
Parametrised menu selection controller for N vertically stacked menu items. It hit-tests the mouse pointer against the item rectangles and runs a press/release state machine to confirm a choice. It overlays hover, press and selected borders onto the incoming video stream. It sits at the end of the menu text-overlay chain, after the last text-drawing stage, and drives the VGA sync and rgb outputs and the selected-item index.

Parameters:
- N_ITEMS, 4: number of menu items, 1..2**IDX_W.
- IDX_W, 2: width of item index outputs.
- ITEM_X, 384: left x of every item rectangle.
- ITEM_Y0, 72: top y of item 0.
- ITEM_PITCH, 200: vertical distance between item tops.
- ITEM_W, 256: item width in pixels.
- ITEM_H, 64: item height in pixels.
- BORDER, 4: highlight border thickness in pixels.
- HOVER_COLOR, 12'hFF0: border colour for the hovered item.
- PRESS_COLOR, 12'hF80: border colour for the pressed item.
- SEL_COLOR, 12'h0F0: border colour for the selected item.
- DEFAULT_SEL, 0: sel_idx value after reset.

Ports:
- clk in 1: pixel clock.
- rst in 1: synchronous reset, active-high.
- hcount_in in 11: horizontal pixel count.
- vcount_in in 11: vertical line count.
- hsync_in in 1: horizontal sync.
- vsync_in in 1: vertical sync.
- hblnk_in in 1: horizontal blanking.
- vblnk_in in 1: vertical blanking.
- rgb_in in 12: upstream pixel colour.
- xpos in 12: mouse x position.
- ypos in 12: mouse y position.
- mouse_left in 1: left button level, in clk domain.
- hsync_out out 1: hsync delayed 2 cycles.
- vsync_out out 1: vsync delayed 2 cycles.
- rgb_out out 12: composited pixel.
- hover_idx out IDX_W: item under pointer.
- hover_valid out 1: pointer is over some item.
- sel_idx out IDX_W: last confirmed item.
- sel_stb out 1: one-cycle pulse on confirm.

Behaviour:
- Clocking: one clock (clk). Reset is synchronous, active-high. All state is updated on the rising clk edge.
- Reset values: all outputs 0, except sel_idx = DEFAULT_SEL. FSM goes to IDLE and all pipeline registers are cleared.
- Pointer sampling:
  - xpos, ypos and mouse_left are registered on the cycle where vsync_in rises (0->1), i.e. once per frame.
  - Hit test, FSM and borders all use only these frame samples, so a frame never tears.
- Hit test on the samples:
  - Item k occupies ITEM_X <= x < ITEM_X+ITEM_W and ITEM_Y0+k*ITEM_PITCH <= y < ITEM_Y0+k*ITEM_PITCH+ITEM_H, for k < N_ITEMS.
  - Comparisons are unsigned at 12 bits; hcount/vcount are zero-extended to 12 bits.
  - Item rectangles are non-overlapping by construction (ITEM_PITCH >= ITEM_H). If several items match, the lowest k wins.
  - hover_valid/hover_idx update 1 cycle after the sampling edge. When no item is hit, hover_valid=0 and hover_idx holds its last value.
- Button edges are taken between consecutive frame samples (press = 0->1, release = 1->0).
- FSM, evaluated once per frame sample:
  - IDLE: press over item k -> latch press_idx=k, go to PRESS. Press over no item -> WAIT_REL.
  - PRESS: release over press_idx -> CONFIRM. Release elsewhere -> IDLE, no selection change. Pointer leaving the item while the button is held keeps PRESS.
  - WAIT_REL: release -> IDLE.
  - CONFIRM: lasts exactly 1 clk. sel_idx <= press_idx, sel_stb=1, then go to IDLE.
  - Re-selecting the current sel_idx still produces a sel_stb pulse.
- Video pipeline, latency exactly 2 clk for hsync, vsync, blanking and rgb:
  - Stage 1 registers the timing signals and rgb_in, and computes per-item inside-rectangle and inside-border flags.
  - Border region of item k: inside the rectangle, and within BORDER pixels of any rectangle edge.
- Stage 2 colour priority, highest first:
  1. blanking (delayed hblnk|vblnk) -> 12'h000
  2. border of sel_idx -> SEL_COLOR
  3. border of press_idx, while in PRESS -> PRESS_COLOR
  4. border of hover_idx, when hover_valid -> HOVER_COLOR
  5. otherwise -> delayed rgb_in
- Reset mid-operation: an active press or pending confirm is dropped, and no sel_stb is produced.
- N_ITEMS=1: the single item works normally. IDX_W must satisfy 2**IDX_W >= N_ITEMS; this is checked at elaboration.

Test Plan:
- Reset: assert rst for 3 cycles -> rgb_out=0, sel_idx=0, sel_stb=0, hover_valid=0. With no pointer activity, the outputs hold these values.
- Latency: pointer off all items, rgb_in=12'h123 at hcount=100, vcount=100 -> rgb_out=12'h123 and hsync_out/vsync_out match the inputs exactly 2 cycles later.
- Hover: xpos=400, ypos=300 sampled at a vsync edge -> hover_valid=1, hover_idx=1. Pixel (384,272) -> HOVER_COLOR. Pixel (500,300) -> passes rgb_in. Pixel (387,300) -> HOVER_COLOR. Pixel (388,300) -> passes rgb_in.
- Confirm: press at (400,500), release at (400,510) on the next frame -> one sel_stb pulse, sel_idx=2, and item 2's border shows SEL_COLOR from the next frame.
- Abort: press on item 3 at (400,700), release at (100,100) -> no sel_stb, sel_idx unchanged. Press at (100,100), then release over item 0 -> no sel_stb.
- Blanking and priority: hover over sel_idx item -> SEL_COLOR. Blanking asserted inside a border -> 12'h000. rst during PRESS -> no sel_stb, sel_idx=DEFAULT_SEL.
